bcd_conv_arbiter: RTL and testbench
===================================

// Module: bcd_conv_arbiter
// PURPOSE
//  Shares one hex-to-BCD converter (6-bit high / 7-bit low in, 4x BCD digits out) between
//  N_REQ requesters (stopwatch, clock, alarm displays). Round-robin grant, drives the
//  converter's active-low start pulse, waits for its done window, returns digits plus ack.
//  Sits between the time-keeping counters and the converter, upstream of the FND scanner.
// PARAMETERS
//  N_REQ      3    number of requesters (2..8)
//  START_LOW  2    cycles conv_start_n is held low per conversion (>=2, converter has 2-FF sync)
//  TIMEOUT    63   max cycles in WAIT for conv_done before error abort
// PORTS
//  clk        in   1         system clock, all logic on rising edge
//  rst        in   1         asynchronous, active-low reset
//  req        in   N_REQ     level request per requester; held until its ack
//  h_val      in   6*N_REQ   packed high-field values, slice i = requester i
//  l_val      in   7*N_REQ   packed low-field values
//  ack        out  N_REQ     one-hot 1-cycle pulse: result for requester i is on rsp_*
//  rsp_bcd    out  16        {a,b,c,d} digits, valid only in ack cycle
//  rsp_err    out  1         with ack: conversion failed/rejected, rsp_bcd = 0
//  busy       out  1         high in every state except IDLE
//  conv_start_n out 1        to converter start; idles high, falling edge launches conversion
//  conv_h     out  6         latched high value to converter
//  conv_l     out  7         latched low value to converter
//  conv_done  in   1         converter done (high for a multi-cycle window)
//  conv_bcd   in   16        converter digits {a,b,c,d}
// BEHAVIOUR
//  Reset: state IDLE, ack=0, rsp_bcd=0, rsp_err=0, busy=0, conv_start_n=1, conv_h/l=0,
//   rr pointer=0. Reset mid-conversion aborts silently (no ack); converter left to finish.
//  FSM: IDLE -> START -> WAIT -> CAPTURE -> GAP -> IDLE.
//  IDLE: if any req, grant = first requester with req set at/after pointer (wrapping);
//   latch its h/l slices into conv_h/conv_l, store grant index; -> START next cycle.
//  START: conv_start_n=0 for START_LOW cycles, then 1; -> WAIT. conv_h/l stable from grant
//   until GAP exit.
//  WAIT: rising edge of conv_done (registered prev value) -> CAPTURE. Counter reaches
//   TIMEOUT without edge -> ack[grant]=1, rsp_err=1, rsp_bcd=0, -> GAP.
//  CAPTURE: one cycle: rsp_bcd<=conv_bcd, ack[grant]=1, rsp_err=0; -> GAP.
//  GAP: wait until conv_done low, then one extra cycle -> IDLE. Pointer = grant+1 mod N_REQ
//   updated on ack. Min issue-to-ack latency = 1+START_LOW+converter latency+1.
//  Requester dropping req after grant: conversion still completes, ack still pulses (ignorable).
//  req from the acked requester in the ack cycle is not re-granted until IDLE (no back-to-back
//   starvation; other pending requesters win next by round robin).
//  conv_done already high on entering WAIT: not an edge; rely on GAP of previous op; timeout.
// CONFIGURATION
//  BCD_RANGE_CHECK_EN defined: in IDLE, granted value with h>59 or l>99 is rejected without
//   conversion: next cycle ack[grant]=1, rsp_err=1, rsp_bcd=0, pointer advances, -> IDLE.
//  Not defined: all values converted; out-of-range digits are whatever the converter gives.
// STRUCTURE
//  Shared package bcd_arb_pkg: state encoding (IDLE,START,WAIT,CAPTURE,GAP), widths H_W=6,
//   L_W=7, BCD_W=16, range limits H_MAX=59, L_MAX=99.
//  Sub-module rr_pick: combinational round-robin selector (req, pointer -> one-hot grant,
//   index, any). FSM, counters, latches in top.
// TESTING (bench includes behavioural converter model with done high for 14 cycles)
//  1 single req[0], h=23,l=45 -> conv_start_n low 2 cycles, ack=3'b001, rsp_bcd=16'h2345.
//  2 req=3'b111 held, values 01/02/03 -> acks in order 0,1,2,0; pointer wraps; no overlap.
//  3 converter model never asserts done -> after 63 WAIT cycles ack with rsp_err=1, bcd=0.
//  4 rst low during WAIT -> all outputs to reset values same cycle; after release, new req ok.
//  5 BCD_RANGE_CHECK_EN, h=60,l=10 -> ack+rsp_err, no conv_start_n edge; without macro,
//   conversion runs, rsp_err=0.
//  6 req[1] dropped one cycle after grant -> ack[1] still pulses, next grant goes to req[2].

Source files
------------

// File: rtl/bcd_arb_pkg.sv
// Shared types and limits for the BCD converter arbiter: FSM state encoding,
// field widths and the valid range of the high/low time fields.
`timescale 1ns/1ps
package bcd_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    CAPTURE,
    GAP
  } state_t;

  localparam int H_W   = 6;
  localparam int L_W   = 7;
  localparam int BCD_W = 16;

  localparam logic [H_W-1:0] H_MAX = 6'd59;
  localparam logic [L_W-1:0] L_MAX = 7'd99;

endpackage

// File: rtl/bcd_conv_arbiter_rr_pick.sv
// Combinational round-robin selector: lowest requester index at or after the
// pointer wins, wrapping to the lowest index overall when none is at/after it.
`timescale 1ns/1ps
module rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_oh,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  // Second pass overrides the wrapped choice whenever a requester sits at/after ptr.
  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant_idx = IDX_W'(i);
        any       = 1'b1;
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(ptr))) begin
        grant_idx = IDX_W'(i);
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign grant_oh[gi] = any && (grant_idx == IDX_W'(gi));
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one hex-to-BCD converter between N_REQ requesters.
// Define BCD_RANGE_CHECK_EN to reject out-of-range values (h>59 or l>99) without converting.
`timescale 1ns/1ps
module bcd_conv_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int START_LOW = 2,
  parameter int TIMEOUT   = 63
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [H_W*N_REQ-1:0] h_val,
  input  logic [L_W*N_REQ-1:0] l_val,
  output logic [N_REQ-1:0]     ack,
  output logic [BCD_W-1:0]     rsp_bcd,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 conv_start_n,
  output logic [H_W-1:0]       conv_h,
  output logic [L_W-1:0]       conv_l,
  input  logic                 conv_done,
  input  logic [BCD_W-1:0]     conv_bcd
);

  localparam int IDX_W   = $clog2(N_REQ);
  localparam int CNT_MAX = (TIMEOUT > START_LOW) ? TIMEOUT : START_LOW;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

`ifdef BCD_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic                 gap_low_q, gap_low_d;
  logic                 done_prev_q;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic [BCD_W-1:0]     rsp_bcd_q, rsp_bcd_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 busy_q, busy_d;
  logic                 conv_start_n_q, conv_start_n_d;
  logic [H_W-1:0]       conv_h_q, conv_h_d;
  logic [L_W-1:0]       conv_l_q, conv_l_d;

  logic [N_REQ-1:0]     eligible;
  logic [N_REQ-1:0]     pick_oh;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [H_W-1:0]       h_sel;
  logic [L_W-1:0]       l_sel;
  logic                 reject;
  logic                 done_rise;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
    return (g == IDX_W'(N_REQ - 1)) ? '0 : g + 1'b1;
  endfunction

  // A requester still holding req during its own ack cycle must not win again.
  assign eligible = req & ~ack_q;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req       (eligible),
    .ptr       (ptr_q),
    .grant_oh  (pick_oh),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  assign h_sel     = h_val[int'(pick_idx) * H_W +: H_W];
  assign l_sel     = l_val[int'(pick_idx) * L_W +: L_W];
  assign reject    = RANGE_CHECK && ((h_sel > H_MAX) || (l_sel > L_MAX));
  assign done_rise = conv_done && !done_prev_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    grant_d        = grant_q;
    ptr_d          = ptr_q;
    gap_low_d      = gap_low_q;
    ack_d          = '0;
    rsp_bcd_d      = '0;
    rsp_err_d      = 1'b0;
    conv_start_n_d = 1'b1;
    conv_h_d       = conv_h_q;
    conv_l_d       = conv_l_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          if (reject) begin
            ack_d     = pick_oh;
            rsp_err_d = 1'b1;
            ptr_d     = next_ptr(pick_idx);
          end else begin
            conv_h_d       = h_sel;
            conv_l_d       = l_sel;
            conv_start_n_d = 1'b0;
            cnt_d          = '0;
            state_d        = START;
          end
        end
      end
      START: begin
        if (cnt_q == CNT_W'(START_LOW - 1)) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          conv_start_n_d = 1'b0;
          cnt_d          = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (done_rise) begin
          state_d = CAPTURE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          ack_d[grant_q] = 1'b1;
          rsp_err_d      = 1'b1;
          ptr_d          = next_ptr(grant_q);
          gap_low_d      = 1'b0;
          state_d        = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CAPTURE: begin
        rsp_bcd_d      = conv_bcd;
        ack_d[grant_q] = 1'b1;
        ptr_d          = next_ptr(grant_q);
        gap_low_d      = 1'b0;
        state_d        = GAP;
      end
      GAP: begin
        // Hold off the next launch until the done window has closed plus one cycle.
        if (gap_low_q) begin
          gap_low_d = 1'b0;
          state_d   = IDLE;
        end else if (!conv_done) begin
          gap_low_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      grant_q        <= '0;
      ptr_q          <= '0;
      gap_low_q      <= 1'b0;
      done_prev_q    <= 1'b0;
      ack_q          <= '0;
      rsp_bcd_q      <= '0;
      rsp_err_q      <= 1'b0;
      busy_q         <= 1'b0;
      conv_start_n_q <= 1'b1;
      conv_h_q       <= '0;
      conv_l_q       <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      grant_q        <= grant_d;
      ptr_q          <= ptr_d;
      gap_low_q      <= gap_low_d;
      done_prev_q    <= conv_done;
      ack_q          <= ack_d;
      rsp_bcd_q      <= rsp_bcd_d;
      rsp_err_q      <= rsp_err_d;
      busy_q         <= busy_d;
      conv_start_n_q <= conv_start_n_d;
      conv_h_q       <= conv_h_d;
      conv_l_q       <= conv_l_d;
    end
  end

  assign ack          = ack_q;
  assign rsp_bcd      = rsp_bcd_q;
  assign rsp_err      = rsp_err_q;
  assign busy         = busy_q;
  assign conv_start_n = conv_start_n_q;
  assign conv_h       = conv_h_q;
  assign conv_l       = conv_l_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter: behavioural converter, ack scoreboard and per-cycle checks.
// Honours BCD_RANGE_CHECK_EN for the out-of-range scenario.
`timescale 1ns/1ps
module tb_bcd_conv_arbiter;

  localparam int N_REQ     = 3;
  localparam int START_LOW = 2;
  localparam int TIMEOUT   = 63;
  localparam int DONE_LEN  = 14;
  localparam int CONV_DLY  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [17:0] h_val = '0;
  logic [20:0] l_val = '0;
  logic [2:0]  ack;
  logic [15:0] rsp_bcd;
  logic        rsp_err;
  logic        busy;
  logic        conv_start_n;
  logic [5:0]  conv_h;
  logic [6:0]  conv_l;
  logic        conv_done = 1'b0;
  logic [15:0] conv_bcd;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_conv_arbiter #(
    .N_REQ     (N_REQ),
    .START_LOW (START_LOW),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .h_val        (h_val),
    .l_val        (l_val),
    .ack          (ack),
    .rsp_bcd      (rsp_bcd),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .conv_start_n (conv_start_n),
    .conv_h       (conv_h),
    .conv_l       (conv_l),
    .conv_done    (conv_done),
    .conv_bcd     (conv_bcd)
  );

  function automatic logic [15:0] bcd_model(input int h, input int l);
    return {4'(h / 10), 4'(h % 10), 4'(l / 10), 4'(l % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Converter: 2-FF synchronised start, result after CONV_DLY, done high DONE_LEN cycles.
  logic        conv_en  = 1'b1;
  logic        sync1    = 1'b1;
  logic        sync2    = 1'b1;
  int          conv_cnt = 0;
  logic [15:0] conv_res = '0;
  assign conv_bcd = conv_res;

  always @(posedge clk) begin
    sync1 <= conv_start_n;
    sync2 <= sync1;
    if (conv_en && !sync1 && sync2) begin
      conv_res  <= bcd_model(int'(conv_h), int'(conv_l));
      conv_cnt  <= CONV_DLY + DONE_LEN;
      conv_done <= 1'b0;
    end else if (conv_cnt > 0) begin
      conv_done <= (conv_cnt <= DONE_LEN);
      conv_cnt  <= conv_cnt - 1;
    end else begin
      conv_done <= 1'b0;
    end
  end

  typedef struct {
    int          idx;
    logic [15:0] bcd;
    logic        err;
    bit          chk_hl;
    int          h;
    int          l;
    bit          tmo;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  task automatic push_exp(input int idx, input logic [15:0] bcd, input logic err,
                          input bit chk_hl, input int h, input int l, input bit tmo);
    exp_t x;
    x.idx = idx; x.bcd = bcd; x.err = err; x.chk_hl = chk_hl;
    x.h = h; x.l = l; x.tmo = tmo;
    exp_q.push_back(x);
  endtask

  int cyc = 0;
  int low_run = 0;
  int t_rise = 0;
  int n_starts = 0;
  int n_acks = 0;
  int lat;
  bit outstanding = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      chk("reset_ctrl", 32'({ack, rsp_err, busy, conv_start_n}), 32'(6'b000_0_0_1));
      chk("reset_data", 32'({rsp_bcd, conv_h, conv_l}), 32'(0));
      low_run     = 0;
      outstanding = 1'b0;
    end else begin
      if (!conv_start_n) begin
        if (low_run == 0) begin
          chk("start_overlap", 32'(outstanding), 32'(0));
          outstanding = 1'b1;
          n_starts++;
        end
        low_run++;
        chk("busy_in_start", 32'(busy), 32'(1));
      end else if (low_run > 0) begin
        chk("start_low_cycles", 32'(low_run), 32'(START_LOW));
        low_run = 0;
        t_rise  = cyc;
      end
      if (ack != '0) begin
        n_acks++;
        $display("ack onehot=%b bcd=%04h err=%0b t=%0t", ack, rsp_bcd, rsp_err, $time);
        chk("ack_onehot", 32'($countones(ack)), 32'(1));
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 32'(ack), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("ack_index", 32'(ack), 32'(3'b001 << e.idx));
          chk("rsp_bcd", 32'(rsp_bcd), 32'(e.bcd));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          if (e.chk_hl) chk("conv_hl_held", 32'({conv_h, conv_l}), 32'({6'(e.h), 7'(e.l)}));
          if (e.tmo) begin
            lat = cyc - t_rise;
            chk("timeout_latency", 32'(lat), (lat == TIMEOUT + 1) ? 32'(TIMEOUT + 1) : 32'(TIMEOUT));
          end
        end
        outstanding = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_vals(input int i, input int h, input int l);
    h_val[i*6 +: 6] = 6'(h);
    l_val[i*7 +: 7] = 7'(l);
  endtask

  task automatic wait_acks(input string name, input int target, input int bound);
    int k = 0;
    while (n_acks < target && k < bound) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk(name, 32'(n_acks), 32'(target));
  endtask

  task automatic wait_idle(input string name, input int bound);
    int k = 0;
    while ((busy || conv_done) && k < bound) begin
      tick(1);
      k++;
    end
    chk(name, 32'({busy, conv_done}), 32'(0));
  endtask

  task automatic wait_busy(input string name, input int bound);
    int k = 0;
    while (!busy && k < bound) begin
      tick(1);
      k++;
    end
    chk(name, 32'(busy), 32'(1));
  endtask

  int base;
  int starts0;

  initial begin
    #1 rst = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(2);

    chk("model_pin_a", 32'(bcd_model(7, 8)), 32'(16'h0708));
    chk("model_pin_b", 32'(bcd_model(59, 99)), 32'(16'h5999));

    // 1: single request
    base = n_acks;
    set_vals(0, 23, 45);
    push_exp(0, 16'h2345, 1'b0, 1'b1, 23, 45, 1'b0);
    req = 3'b001;
    wait_acks("t1_ack", base + 1, 200);
    req = 3'b000;
    wait_idle("t1_idle", 100);

    // 3: converter silent -> timeout (pointer now 1, only requester 2 asks)
    base = n_acks;
    conv_en = 1'b0;
    set_vals(2, 12, 34);
    push_exp(2, 16'h0000, 1'b1, 1'b1, 12, 34, 1'b1);
    req = 3'b100;
    wait_acks("t3_ack", base + 1, 300);
    req = 3'b000;
    wait_idle("t3_idle", 100);
    conv_en = 1'b1;

    // 4: reset while waiting for the converter
    base = n_acks;
    set_vals(0, 5, 6);
    req = 3'b001;
    wait_busy("t4_busy", 50);
    tick(START_LOW + 2);
    rst = 1'b0;
    tick(2);
    req = 3'b000;
    rst = 1'b1;
    tick(1);
    chk("t4_busy_after_release", 32'(busy), 32'(0));
    tick(30);
    chk("t4_no_ack", 32'(n_acks), 32'(base));

    // 2: all three requesting, pointer back at 0 -> 0,1,2,0
    base = n_acks;
    for (int i = 0; i < 3; i++) set_vals(i, i + 1, i + 1);
    for (int k = 0; k < 4; k++) push_exp(k % 3, bcd_model(k % 3 + 1, k % 3 + 1), 1'b0, 1'b1,
                                         k % 3 + 1, k % 3 + 1, 1'b0);
    req = 3'b111;
    wait_acks("t2_acks", base + 4, 600);
    req = 3'b000;
    wait_idle("t2_idle", 100);

    // 6: requester 1 withdraws right after its grant; requester 2 follows
    base = n_acks;
    set_vals(1, 11, 22);
    set_vals(2, 33, 44);
    push_exp(1, 16'h1122, 1'b0, 1'b1, 11, 22, 1'b0);
    push_exp(2, 16'h3344, 1'b0, 1'b1, 33, 44, 1'b0);
    req = 3'b110;
    wait_busy("t6_busy", 50);
    tick(1);
    req[1] = 1'b0;
    wait_acks("t6_acks", base + 2, 400);
    req = 3'b000;
    wait_idle("t6_idle", 100);

    // 5: out-of-range value on requester 0
    base = n_acks;
    starts0 = n_starts;
    set_vals(0, 60, 10);
`ifdef BCD_RANGE_CHECK_EN
    push_exp(0, 16'h0000, 1'b1, 1'b0, 60, 10, 1'b0);
`else
    push_exp(0, 16'h6010, 1'b0, 1'b1, 60, 10, 1'b0);
`endif
    req = 3'b001;
    wait_acks("t5_ack", base + 1, 200);
    req = 3'b000;
    wait_idle("t5_idle", 100);
    tick(3);
`ifdef BCD_RANGE_CHECK_EN
    chk("t5_starts", 32'(n_starts - starts0), 32'(0));
    chk("t5_no_regrant", 32'({busy, n_acks - base}), 32'(1));
`else
    chk("t5_starts", 32'(n_starts - starts0), 32'(1));
`endif

    chk("pending_acks", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
